// File: rtl/stream_demux_1xn.sv
// Registered 1-to-NUM_CH stream demultiplexer with packet-locked routing.
// Optional drop counter port and logic enabled by defining STREAM_DEMUX_DROP_CNT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | next accepted beat is a first beat; route taken from in_sel
// ST_PKT   | inside a packet; route taken from r_lock_sel until in_last
module stream_demux_1xn #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 8,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              in_last,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
`ifdef STREAM_DEMUX_DROP_CNT_EN
    ,
    output logic [CNT_W-1:0]  drop_cnt
`endif
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_t;

    localparam logic [SEL_W:0] NUM_CH_LIM = (SEL_W+1)'(NUM_CH);

    state_t             r_state;
    logic [SEL_W-1:0]   r_lock_sel;
    logic               r_full;
    logic [SEL_W-1:0]   r_ch;
    logic [DATA_W-1:0]  r_data;
    logic               r_last;

    logic               w_sel_ready;
    logic               w_accept;
    logic [SEL_W-1:0]   w_route;
    logic               w_in_range;
    logic               w_load;
    logic               w_drain;

    // Only the ready of the channel currently holding a beat matters.
    always_comb begin
        w_sel_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_ch == SEL_W'(i)) begin
                w_sel_ready = out_ready[i];
            end
        end
    end

    always_comb begin
        out_valid = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            out_valid[i] = r_full && (r_ch == SEL_W'(i));
        end
    end

    assign in_ready   = !r_full || w_sel_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_route    = (r_state == ST_PKT) ? r_lock_sel : in_sel;
    assign w_in_range = ({1'b0, w_route} < NUM_CH_LIM);
    assign w_load     = w_accept && w_in_range;
    assign w_drain    = r_full && w_sel_ready;

    assign out_data   = r_data;
    assign out_last   = r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_lock_sel <= '0;
            r_full     <= 1'b0;
            r_ch       <= '0;
            r_data     <= '0;
            r_last     <= 1'b0;
        end else begin
            if (w_accept) begin
                case (r_state)
                    ST_IDLE: begin
                        r_lock_sel <= in_sel;
                        if (!in_last) begin
                            r_state <= ST_PKT;
                        end
                    end
                    ST_PKT: begin
                        if (in_last) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end

            // A load in the drain cycle keeps the register full with the new beat.
            if (w_load) begin
                r_full <= 1'b1;
                r_ch   <= w_route;
                r_data <= in_data;
                r_last <= in_last;
            end else if (w_drain) begin
                r_full <= 1'b0;
            end
        end
    end

`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [CNT_W-1:0] r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_accept && !w_in_range && (r_drop_cnt != {CNT_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Bench for stream_demux_1xn: directed scenarios plus random traffic against a queue-based model.
// Uses NUM_CH=6 with a 3-bit select so out-of-range routes (6, 7) are exercised.
module tb_stream_demux_1xn;

    localparam int DATA_W   = 8;
    localparam int NUM_CH   = 6;
    localparam int SEL_W    = 3;
    localparam int CNT_W    = 2;
    localparam int DROP_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [SEL_W-1:0]  in_sel;
    logic              in_last;
    logic [NUM_CH-1:0] out_valid;
    logic [NUM_CH-1:0] out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [CNT_W-1:0]  drop_cnt;
`endif

    stream_demux_1xn #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
`ifdef STREAM_DEMUX_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int                ch;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    // Model: beats accepted but not yet consumed, plus the packet lock.
    beat_t q[$];
    bit    pkt_open;
    int    pkt_ch;
    int    drops;

    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear;
        q.delete();
        pkt_open = 1'b0;
        pkt_ch   = 0;
        drops    = 0;
    endtask

    // One clock: check outputs at the falling edge, advance the model, return after the rising edge.
    task automatic cycle(output bit acc);
        logic [31:0] exp_v;
        bit          exp_rdy;
        int          route;
        @(negedge clk);
        exp_v = (q.size() != 0) ? (32'd1 << q[0].ch) : 32'd0;
        check("out_valid", 32'(out_valid), exp_v);
        if (q.size() != 0) begin
            check("out_data", 32'(out_data), 32'(q[0].data));
            check("out_last", 32'(out_last), 32'(q[0].last));
        end
        exp_rdy = (q.size() == 0) || out_ready[q[0].ch];
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
`ifdef STREAM_DEMUX_DROP_CNT_EN
        check("drop_cnt", 32'(drop_cnt), 32'(drops));
`endif
        acc = in_valid && exp_rdy;
        if (q.size() != 0 && out_ready[q[0].ch]) begin
            void'(q.pop_front());
        end
        if (acc) begin
            route = pkt_open ? pkt_ch : int'(in_sel);
            if (route < NUM_CH) begin
                q.push_back('{route, in_data, in_last});
            end else if (drops < DROP_MAX) begin
                drops++;
            end
            pkt_open = !in_last;
            pkt_ch   = route;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int sel, input int data, input bit last, input logic [NUM_CH-1:0] rdy);
        bit acc;
        in_valid  = 1'b1;
        in_sel    = SEL_W'(sel);
        in_data   = DATA_W'(data);
        in_last   = last;
        out_ready = rdy;
        cycle(acc);
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid  = 1'b0;
        out_ready = '1;
        for (int i = 0; i < n; i++) cycle(acc);
    endtask

    task automatic do_reset;
        in_valid = 1'b1;
        in_sel   = 3'd4;
        rst_n    = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        model_clear();
        @(posedge clk);
        #1;
        check("rst_hold_valid", 32'(out_valid), 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
    endtask

    initial begin
        bit acc;
        int stall;
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        in_last   = 1'b0;
        out_ready = '1;
        model_clear();
        #3;
        do_reset();
        idle(3);

        // Sweep of single-beat packets over every select value, back to back.
        for (int s = 0; s < 8; s++) beat(s, 8'hA0 + s, 1'b1, '1);
        idle(2);

        // Lock: the later in_sel values must be ignored inside the packet.
        beat(5, 8'h51, 1'b0, '1);
        beat(2, 8'h52, 1'b0, '1);
        beat(2, 8'h53, 1'b1, '1);
        beat(2, 8'h21, 1'b1, '1);
        idle(2);

        // Backpressure on channel 3 for four cycles mid-stream; other readies stay high.
        stall = 0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_sel   = 3'd3;
            in_data  = DATA_W'(8'h30 + k);
            in_last  = (k == 5);
            do begin
                if (k >= 1 && stall < 4) begin
                    out_ready = 6'b110111;
                    stall++;
                end else begin
                    out_ready = '1;
                end
                cycle(acc);
            end while (!acc);
        end
        idle(2);

        // Out-of-range packet is swallowed whole, then normal delivery resumes.
        beat(7, 8'hE1, 1'b0, '1);
        beat(1, 8'hE2, 1'b1, '1);
        beat(1, 8'h11, 1'b1, '1);
        idle(2);
        for (int k = 0; k < 5; k++) beat(6, 8'hF0 + k, 1'b1, '1);
        idle(1);
`ifdef STREAM_DEMUX_DROP_CNT_EN
        check("drop_sat", 32'(drop_cnt), 32'(DROP_MAX));
`endif

        // Reset while in a packet with the register full and stalled.
        beat(2, 8'h12, 1'b0, 6'b111011);
        beat(2, 8'h13, 1'b0, 6'b111011);
        do_reset();
        beat(4, 8'h44, 1'b1, '1);
        idle(2);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = SEL_W'($urandom_range(0, 7));
            in_data   = DATA_W'($urandom);
            in_last   = ($urandom_range(0, 2) == 0);
            for (int c = 0; c < NUM_CH; c++) out_ready[c] = ($urandom_range(0, 9) < 7);
            cycle(acc);
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
